otter_fetch_buffer: RTL
=======================

Name: otter_fetch_buffer

Overview:
Fetch stage for the pipelined OTTER. Owns the PC and issues reads to the synchronous instruction memory port, which has 1-cycle read latency. Returned words land in a small prefetch FIFO tagged with their PC. Decode consumes the FIFO head under a stall signal, and an execute-stage redirect (branch/jump/mret/trap) discards all wrong-path work.

Parameters:
RESET_VEC, 32'h0000_0000, PC loaded on reset
DEPTH, 2, prefetch FIFO entries (legal range 2..8)

Ports:
CLK  in  1  system clock, all state on rising edge
RST_N  in  1  asynchronous active-low reset
REDIRECT  in  1  execute stage requests PC change this cycle
REDIRECT_PC  in  32  target PC; bits [1:0] ignored
STALL  in  1  decode cannot accept (load-use hazard); head held
IMEM_ADDR  out  32  instruction read address, word aligned
IMEM_RD  out  1  read strobe; data valid on IMEM_DOUT the following cycle
IMEM_DOUT  in  32  instruction word for the previous cycle's read
ID_VALID  out  1  head entry valid
ID_IR  out  32  head instruction
ID_PC  out  32  head instruction's PC

Behaviour:
- Reset (async assert, sync release): pc=RESET_VEC, FIFO empty, inflight=0, epoch=0.
- Reset outputs: ID_VALID=0, ID_IR=NOP_INSTR (32'h0000_0013), ID_PC=0, IMEM_RD=0.
- When ID_VALID=0, ID_IR=NOP_INSTR and ID_PC=0.
- pop = ID_VALID & ~STALL & ~REDIRECT.
- Issue condition: issue = REDIRECT | (count + inflight - pop < DEPTH).
- IMEM_RD = issue while RST_N=1.
- IMEM_ADDR = REDIRECT ? {REDIRECT_PC[31:2],2'b00} : pc.
- On issue: pc <= IMEM_ADDR + 4. Also record inflight=1, inflight_pc=IMEM_ADDR, inflight_epoch=epoch (post-redirect value).
- Without issue: inflight <= 0.
- Response: in the cycle after an issue, IMEM_DOUT is pushed as {IMEM_DOUT, inflight_pc} unless REDIRECT is high in that cycle or inflight_epoch != epoch.
- Redirect:
  - Epoch toggles.
  - FIFO cleared (count=0) at the same edge.
  - The response arriving during the redirect cycle is dropped.
  - The read issued in the redirect cycle targets REDIRECT_PC and is kept.
- Latency: REDIRECT in cycle N -> IMEM read in N -> data in N+1 -> ID_VALID=1 with ID_PC=target in N+2.
- Reset release: first read in cycle 0 after RST_N rises; first ID_VALID in cycle 2.
- Steady state with STALL=0: one instruction per cycle, consecutive ID_PC differ by 4.
- Full: count==DEPTH with no pop means no issue, and pc holds. The issue condition guarantees a response always has a free slot, so no overflow case exists.
- Empty with pop requested: nothing happens; ID_VALID=0 and decode sees NOP.
- Push and pop in the same cycle: count unchanged, head advances, the new entry goes to the tail.
- Empty FIFO: a push is not bypassed to the outputs; registered head only.
- STALL and REDIRECT together: REDIRECT wins (flush plus new issue); STALL is ignored.
- PC arithmetic wraps modulo 2^32 (32'hFFFF_FFFC + 4 = 0).
- RST_N asserted mid-operation: all state cleared immediately; any in-flight response after release is ignored because inflight=0.

Decomposition:
- otter_pkg holds NOP_INSTR, the fetch entry struct {ir[31:0], pc[31:0]}, and the RESET_VEC default.
- Sub-module otter_fetch_fifo: DEPTH-entry circular FIFO with push/pop/clear, count output and a registered head. Clear has priority over push.
- The top level holds the PC, the epoch and in-flight tracking, and the issue logic.

Test Plan:
- Reset release, STALL=0, memory returning addr as data: IMEM_ADDR 0,4,8...; ID_VALID rises in cycle 2 with ID_PC=0, ID_IR=0, then ID_PC=4,8 on consecutive cycles.
- STALL held for 3 cycles while streaming:
  - ID_PC frozen at 0x8.
  - IMEM_RD drops once count=2.
  - After release, 0xC and 0x10 follow with no gap or duplicate.
- REDIRECT to 0x100 while FIFO holds 0x10, 0x14 and 0x18 is in flight:
  - The next cycle has ID_VALID=0.
  - The cycle after has ID_PC=0x100.
  - 0x10, 0x14 and 0x18 never appear.
- REDIRECT and STALL together, target 0x203: IMEM_ADDR=0x200 in the same cycle; ID_PC=0x200 two cycles later.
- Two REDIRECTs back to back (0x40 then 0x80): the response for 0x40 is dropped; the first valid ID_PC is 0x80.
- RST_N pulsed low mid-stream:
  - ID_VALID=0, ID_IR=0x13 and IMEM_RD=0 immediately (asynchronous).
  - After release, fetch restarts at RESET_VEC.

Source files
------------

// File: rtl/otter_pkg.sv
// Shared definitions for the OTTER fetch stage: NOP encoding, the fetch entry
// record carried through the prefetch FIFO, and the default reset vector.
package otter_pkg;

    localparam logic [31:0] NOP_INSTR         = 32'h0000_0013;  // addi x0, x0, 0
    localparam logic [31:0] RESET_VEC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] ir;
        logic [31:0] pc;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/otter_fetch_fifo.sv
// DEPTH-entry circular prefetch FIFO holding {ir, pc} records.
// Clear outranks push and pop; the head is always read from stored entries.
module otter_fetch_fifo
    import otter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       CLK,
    input  logic                       RST_N,
    input  logic                       clear,
    input  logic                       push,
    input  fetch_entry_t               push_entry,
    input  logic                       pop,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       head_valid,
    output fetch_entry_t               head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign head_valid = (count != '0);
    assign do_pop     = pop & head_valid;
    // A push into a full FIFO is only accepted when the head leaves in the same cycle.
    assign do_push    = push & ((count != FULL_CNT) | do_pop);
    assign head       = mem[rd_ptr];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (do_push && !clear) mem[wr_ptr] <= push_entry;
    end

endmodule

// File: rtl/otter_fetch_buffer.sv
// OTTER fetch stage: owns the PC, issues 1-cycle-latency IMEM reads and
// tags responses with an epoch so redirects discard wrong-path words.
module otter_fetch_buffer
    import otter_pkg::*;
#(
    parameter logic [31:0] RESET_VEC = RESET_VEC_DEFAULT,
    parameter int          DEPTH     = 2
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        REDIRECT,
    input  logic [31:0] REDIRECT_PC,
    input  logic        STALL,
    output logic [31:0] IMEM_ADDR,
    output logic        IMEM_RD,
    input  logic [31:0] IMEM_DOUT,
    output logic        ID_VALID,
    output logic [31:0] ID_IR,
    output logic [31:0] ID_PC
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [31:0]      pc;
    logic             epoch;
    logic             epoch_nxt;
    logic             inflight;
    logic [31:0]      inflight_pc;
    logic             inflight_epoch;
    logic [CNT_W-1:0] count;
    logic [CNT_W:0]   occupancy;
    logic             issue;
    logic             pop;
    logic             push;
    logic             head_valid;
    fetch_entry_t     head;
    fetch_entry_t     push_entry;

    // Decode handshake: ID_VALID is the valid, ~STALL the ready; the head
    // retires only when both hold and no redirect is flushing the stage.
    assign pop = head_valid & ~STALL & ~REDIRECT;

    // Slots already promised (stored + in flight) minus the one leaving;
    // pop implies count >= 1, so the subtraction cannot underflow.
    assign occupancy = (CNT_W+1)'(count) + (CNT_W+1)'(inflight) - (CNT_W+1)'(pop);
    assign issue     = REDIRECT | (occupancy < (CNT_W+1)'(DEPTH));

    assign epoch_nxt = epoch ^ REDIRECT;
    assign IMEM_ADDR = REDIRECT ? word_align(REDIRECT_PC) : pc;
    assign IMEM_RD   = issue & RST_N;

    // A response survives only if no redirect happened since it was issued.
    assign push       = inflight & ~REDIRECT & (inflight_epoch == epoch);
    assign push_entry = '{ir: IMEM_DOUT, pc: inflight_pc};

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pc             <= RESET_VEC;
            epoch          <= 1'b0;
            inflight       <= 1'b0;
            inflight_pc    <= '0;
            inflight_epoch <= 1'b0;
        end else begin
            epoch    <= epoch_nxt;
            inflight <= issue;
            if (issue) begin
                pc             <= IMEM_ADDR + 32'd4;
                inflight_pc    <= IMEM_ADDR;
                inflight_epoch <= epoch_nxt;
            end
        end
    end

    otter_fetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .clear      (REDIRECT),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .count      (count),
        .head_valid (head_valid),
        .head       (head)
    );

    assign ID_VALID = head_valid;
    assign ID_IR    = head_valid ? head.ir : NOP_INSTR;
    assign ID_PC    = head_valid ? head.pc : 32'h0000_0000;

endmodule
